// File: rtl/decryption_core_pkg.sv
// Shared AES definitions: FSM state encoding, round count and GF(2^8) helpers,
// kept here so the encryption core can reuse the same arithmetic.
package decryption_core_pkg;

    localparam int AES_NR = 14;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_ROUND = 2'd1;
    localparam fsm_state_t ST_FINAL = 2'd2;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // Column bytes are ordered top row first: col[31:24] is row 0.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: purely combinational 8-bit lookup.
module aes_inv_sbox (
    input  logic [7:0] data,
    output logic [7:0] result
);

    // Row 0 of the FIPS-197 table sits in the most significant bits.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign result = INV_SBOX[{~data, 3'b111} -: 8];

endmodule

// File: rtl/decryption_core.sv
// Iterative AES-256 decryption: one 128-bit state register and one shared
// inverse round, 14 clock edges from the accepting edge to a valid Plaintext.
module decryption_core
    import decryption_core_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         start,
    input  logic [127:0] Ciphertext,
    input  logic [127:0] in_key0,
    input  logic [127:0] in_key1,
    input  logic [127:0] in_key2,
    input  logic [127:0] in_key3,
    input  logic [127:0] in_key4,
    input  logic [127:0] in_key5,
    input  logic [127:0] in_key6,
    input  logic [127:0] in_key7,
    input  logic [127:0] in_key8,
    input  logic [127:0] in_key9,
    input  logic [127:0] in_key10,
    input  logic [127:0] in_key11,
    input  logic [127:0] in_key12,
    input  logic [127:0] in_key13,
    input  logic [127:0] in_key14,
    output logic [127:0] Plaintext,
    output logic         finished,
    output logic         busy
);

    fsm_state_t   fsm;
    logic [3:0]   cnt;
    logic [127:0] state_q;
    logic [127:0] round_keys [0:14];
    logic [127:0] round_key;
    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    assign round_keys[0]  = in_key0;
    assign round_keys[1]  = in_key1;
    assign round_keys[2]  = in_key2;
    assign round_keys[3]  = in_key3;
    assign round_keys[4]  = in_key4;
    assign round_keys[5]  = in_key5;
    assign round_keys[6]  = in_key6;
    assign round_keys[7]  = in_key7;
    assign round_keys[8]  = in_key8;
    assign round_keys[9]  = in_key9;
    assign round_keys[10] = in_key10;
    assign round_keys[11] = in_key11;
    assign round_keys[12] = in_key12;
    assign round_keys[13] = in_key13;
    assign round_keys[14] = in_key14;

    // The counter reaches 0 on entering FINAL, so it selects in_key0 there too.
    assign round_key = round_keys[cnt];

    // Byte (r,c) lives at index r + 4c, most significant byte first.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 127 - 8 * (r + 4 * c);
            localparam int SRC = 127 - 8 * (r + 4 * ((c - r + 4) % 4));

            assign shifted[DST -: 8] = state_q[SRC -: 8];

            aes_inv_sbox u_inv_sbox (
                .data   (shifted[DST -: 8]),
                .result (subbed[DST -: 8])
            );
        end

        assign mixed[127 - 32 * c -: 32] = inv_mix_column(keyed[127 - 32 * c -: 32]);
    end

    assign keyed = subbed ^ round_key;

    // Only NR = 14 is meaningful; the counter is 4 bits wide.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fsm       <= ST_IDLE;
            cnt       <= '0;
            state_q   <= '0;
            Plaintext <= '0;
            finished  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            finished <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= Ciphertext ^ round_keys[NR];
                        cnt     <= 4'(NR - 1);
                        busy    <= 1'b1;
                        fsm     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_q <= mixed;
                    cnt     <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        fsm <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    Plaintext <= keyed;
                    finished  <= 1'b1;
                    busy      <= 1'b0;
                    fsm       <= ST_IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    fsm  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decryption_core.sv
// Scoreboarded bench for decryption_core: expected plaintexts come from known
// answer vectors or from a forward AES-256 model encrypting random blocks.
module tb_decryption_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] plaintext;
    logic         finished;
    logic         busy;
    logic [127:0] rk [15];

    decryption_core #(.NR(14)) dut (
        .CLK        (clk),
        .RSTn       (rst_n),
        .start      (start),
        .Ciphertext (ciphertext),
        .in_key0    (rk[0]),
        .in_key1    (rk[1]),
        .in_key2    (rk[2]),
        .in_key3    (rk[3]),
        .in_key4    (rk[4]),
        .in_key5    (rk[5]),
        .in_key6    (rk[6]),
        .in_key7    (rk[7]),
        .in_key8    (rk[8]),
        .in_key9    (rk[9]),
        .in_key10   (rk[10]),
        .in_key11   (rk[11]),
        .in_key12   (rk[12]),
        .in_key13   (rk[13]),
        .in_key14   (rk[14]),
        .Plaintext  (plaintext),
        .finished   (finished),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t         sb_q [$];
    exp_t         mon_e;
    int           cycle = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic         pt_moved = 1'b0;
    logic [127:0] pt_prev = '0;
    logic [7:0]   sb_tab [256];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    endtask

    // ---------------- forward AES-256 reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = '0;
        logic [7:0] p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = p[7] ? ((p << 1) ^ 8'h1b) : (p << 1);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int k = 0; k < 15; k++) rk[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[0][127 - 8 * i -: 8];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r + 4 * c] = t[r + 4 * ((c + r) % 4)];
            if (rnd < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8 * i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- monitor: pops the scoreboard on every finished pulse ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            pt_prev  = plaintext;
            pt_moved = 1'b0;
        end else begin
            if (finished) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_finish: got pulse at cycle %0d, want none", cycle);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("plaintext", plaintext, mon_e.pt);
                    checkOutput("latency_cycle", 128'(cycle), 128'(mon_e.due));
                    checkOutput("plaintext_held", 128'(pt_moved), 128'd0);
                end
                pt_moved = 1'b0;
            end else if (plaintext !== pt_prev) begin
                pt_moved = 1'b1;
            end
            pt_prev = plaintext;
        end
    end

    // ---------------- driver helpers (all called at posedge + 1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] pt);
        exp_t e;
        e.pt  = pt;
        e.due = cycle + 15;
        sb_q.push_back(e);
        ciphertext = ct;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain", 128'(sb_q.size()), 128'd0);
        sb_q.delete();
    endtask

    logic [127:0] kat_ct [4];
    logic [127:0] kat_pt [4];
    logic [127:0] rnd_pt;
    int           n_wait;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion by time %0t, want completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        kat_ct[0] = 128'h0bdf7df1591716335e9a8b15c860c502;
        kat_ct[1] = 128'h5a6e699d536119065433863c8f657b94;
        kat_ct[2] = 128'h1bc12c9c01610d5d0d8bd6a3378eca62;
        kat_ct[3] = 128'h2956e1c8693536b1bee99c73a31576b6;
        kat_pt[0] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        kat_pt[1] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
        kat_pt[2] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
        kat_pt[3] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;

        rst_n      = 1'b0;
        start      = 1'b0;
        ciphertext = '0;
        for (int k = 0; k < 15; k++) rk[k] = '0;
        build_sbox();
        repeat (3) tick();
        checkOutput("reset_plaintext", plaintext, 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_finished", 128'(finished), 128'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] FIPS-197 C.3 vector");
        load_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        applyStimulus(128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff);
        checkOutput("busy_running", 128'(busy), 128'd1);
        wait_drain(30);
        checkOutput("busy_idle", 128'(busy), 128'd0);

        $display("[TB] SP800-38A AES-256 blocks");
        load_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(kat_ct[i], kat_pt[i]);
            wait_drain(30);
        end

        $display("[TB] back-to-back start on the finished cycle");
        applyStimulus(kat_ct[0], kat_pt[0]);
        n_wait = 0;
        while (!finished && n_wait < 30) begin
            tick();
            n_wait++;
        end
        checkOutput("b2b_first_finished", 128'(finished), 128'd1);
        applyStimulus(kat_ct[1], kat_pt[1]);
        wait_drain(40);

        $display("[TB] start while busy is ignored");
        applyStimulus(kat_ct[2], kat_pt[2]);
        repeat (4) tick();
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_drain(30);
        repeat (20) tick();

        $display("[TB] reset in the middle of an operation");
        applyStimulus(kat_ct[3], kat_pt[3]);
        repeat (7) tick();
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        checkOutput("abort_plaintext", plaintext, 128'd0);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_finished", 128'(finished), 128'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(kat_ct[0], kat_pt[0]);
        wait_drain(40);

        $display("[TB] random round trips through the forward model");
        for (int b = 0; b < 100; b++) begin
            if (b % 10 == 0)
                load_key({$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom});
            rnd_pt = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(model_encrypt(rnd_pt), rnd_pt);
            wait_drain(30);
        end

        repeat (20) tick();
        checkOutput("queue_empty", 128'(sb_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decryption_core.md
DECRYPTION_CORE -- requirements
Module: decryption_core

Interface
REQ-001 SHALL have parameter NR, default 14, meaning the AES round count; only 14 (AES-256) is supported.
REQ-002 SHALL have port CLK  input  1  system clock, all state updates on the rising edge.
REQ-003 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to decrypt Ciphertext.
REQ-005 SHALL have port Ciphertext  input  128  block to decrypt, sampled only on the accepting edge.
REQ-006 SHALL have ports in_key0..in_key14  input  128 each  encryption-order round keys; in_key0/in_key1 = cipher key [255:128]/[127:0], in_key2..in_key14 = Key_Expansion outputs k1..k13.
REQ-007 SHALL have port Plaintext  output  128  registered decryption result.
REQ-008 SHALL have port finished  output  1  one-cycle pulse marking Plaintext valid.
REQ-009 SHALL have port busy  output  1  high while a decryption is in progress.

Function
REQ-010 SHALL run FSM states IDLE, ROUND, FINAL; IDLE is the reset state.
REQ-011 In IDLE, start=1 at a rising edge SHALL load state <= Ciphertext XOR in_key14, set round counter to 13, and enter ROUND.
REQ-012 In ROUND, each edge SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(in_key[cnt]), InvMixColumns, then decrement cnt; after cnt=1 it SHALL enter FINAL.
REQ-013 FINAL SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(in_key0), write the result to Plaintext, pulse finished for exactly one cycle, and return to IDLE.
REQ-014 Latency SHALL be fixed: with the accepting edge as E0, Plaintext is updated and finished rises at E14 and falls at E15.
REQ-015 busy SHALL be high from E0 through E14 and low in IDLE.
REQ-016 start while busy SHALL be ignored; no queuing.
REQ-017 start in the same cycle finished is high SHALL be accepted, giving a back-to-back throughput of one block per 15 cycles.
REQ-018 Plaintext SHALL hold its last value until the next FINAL and SHALL NOT change during ROUND.
REQ-019 The round keys are not latched: the user SHALL hold in_key0..in_key14 stable from E0 to E14. Changing them mid-operation gives undefined results but SHALL NOT hang the FSM.
REQ-020 InvMixColumns SHALL use GF(2^8) arithmetic with polynomial 0x11B and coefficients {0e,0b,0d,09}.
REQ-021 Byte order SHALL be FIPS-197: bits [127:120] are byte 0, and state is column-major.

Reset
REQ-022 RSTn low SHALL immediately force FSM to IDLE, cnt=0, state register=0, Plaintext=0, finished=0, busy=0, regardless of the clock.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no finished pulse; after deassertion the block SHALL accept start on the first edge.

Structure
REQ-024 A shared package SHALL hold the FSM state typedef, the NR constant, and the GF xtime/multiply functions, for reuse by the encryption core.
REQ-025 The inverse S-box SHALL be one sub-module, aes_inv_sbox (8-bit combinational lookup), instantiated 16 times.
REQ-026 The core, excluding aes_inv_sbox, SHALL be 120-400 lines: one registered 128-bit state and one shared round datapath.

Verification
REQ-027 Test 1: Key_Expansion on key 000102..1e1f; Ciphertext 8ea2b7ca516745bfeafc49904b496089 -> Plaintext 00112233445566778899aabbccddeeff; finished exactly 14 edges after E0 (FIPS-197 C.3).
REQ-028 Test 2: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
- Ciphertexts 0bdf7df1591716335e9a8b15c860c502, 5a6e699d536119065433863c8f657b94, 1bc12c9c01610d5d0d8bd6a3378eca62, 2956e1c8693536b1bee99c73a31576b6.
- Expected Plaintext f0f1..fcfdfeff, ..ff00, ..ff01, ..ff02 respectively.
REQ-029 Test 3: start asserted on the finished cycle -> second block accepted, and its result appears exactly 15 cycles after the first result.
REQ-030 Test 4: start pulsed at E5 of a running operation -> ignored; exactly one finished pulse and the correct Plaintext.
REQ-031 Test 5: RSTn pulsed low at E7 -> Plaintext=0, busy=0, no finished pulse; a following start gives the correct result.
REQ-032 Test 6: round trip -> feeding Encryption_Core output into decryption_core with the same keys returns the original plaintext for 100 random blocks.
